// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file and its bus slave FSM.
package regfile_mp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } bus_state_t;

  // Active-low strobe levels
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Wait-state counter width (WAIT_ST up to 15)
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/regfile_mp_bus_fsm.sv
// Bus slave handshake: latches a request, counts wait states, issues a
// one-cycle access (acc_en) and drives the active-low ready.
module regfile_mp_bus_fsm
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned WAIT_ST = 1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_we_,
  input  logic              b_as_,
  input  logic              b_cs_,
  output logic              b_rdy_,
  output logic              acc_en,
  output logic              acc_we,
  output logic [ADDR_W-1:0] acc_addr,
  output logic [DATA_W-1:0] acc_wdata,
  output logic              rd_load,
  output logic [ADDR_W-1:0] rd_addr
);

  bus_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic             req;

  assign req    = (b_cs_ == ENABLE_) && (b_as_ == ENABLE_);
  assign acc_we = acc_en && (we_q == ENABLE_);

  // Read data is captured on the edge that enters ACK; with no wait states
  // that edge is also the one latching the request, so use the live address.
  always_comb begin
    rd_load = 1'b0;
    rd_addr = acc_addr;
    unique case (state)
      ST_IDLE: begin
        rd_load = req && (b_we_ == DISABLE_) && (WAIT_ST == 0);
        rd_addr = b_addr;
      end
      ST_WAIT: rd_load = (b_cs_ == ENABLE_) && (cnt <= CNT_W'(1)) && (we_q == DISABLE_);
      default: rd_load = 1'b0;
    endcase
  end

  // Handshake state machine with registered ready and access strobe
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      we_q      <= DISABLE_;
      acc_addr  <= '0;
      acc_wdata <= '0;
      acc_en    <= 1'b0;
      b_rdy_    <= DISABLE_;
    end else begin
      acc_en <= 1'b0;
      b_rdy_ <= DISABLE_;
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            acc_addr  <= b_addr;
            acc_wdata <= b_wdata;
            we_q      <= b_we_;
            cnt       <= CNT_W'(WAIT_ST);
            if (WAIT_ST == 0) begin
              state  <= ST_ACK;
              acc_en <= 1'b1;
              b_rdy_ <= ENABLE_;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (b_cs_ == DISABLE_) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt <= CNT_W'(1)) begin
            cnt    <= '0;
            state  <= ST_ACK;
            acc_en <= 1'b1;
            b_rdy_ <= ENABLE_;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_ACK:  state <= ST_HOLD;
        ST_HOLD: if (b_as_ == DISABLE_) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two forwarding CPU read ports, one byte-enabled
// CPU write port, and a wait-stated bus slave port for debug access.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned WAIT_ST = 1,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic [ADDR_W-1:0]   ra_addr,
  output logic [DATA_W-1:0]   ra_data,
  input  logic [ADDR_W-1:0]   rb_addr,
  output logic [DATA_W-1:0]   rb_data,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_be,
  input  logic                w_we_,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata,
  input  logic                b_we_,
  input  logic                b_as_,
  input  logic                b_cs_,
  output logic                b_rdy_
);

  localparam int unsigned DEPTH  = 2**ADDR_W;
  localparam int unsigned NBYTES = DATA_W/8;

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  logic              acc_en;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              rd_load;
  logic [ADDR_W-1:0] rd_addr;

  regfile_mp_bus_fsm #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .WAIT_ST (WAIT_ST)
  ) u_bus_fsm (
    .clk       (clk),
    .reset_    (reset_),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_we_     (b_we_),
    .b_as_     (b_as_),
    .b_cs_     (b_cs_),
    .b_rdy_    (b_rdy_),
    .acc_en    (acc_en),
    .acc_we    (acc_we),
    .acc_addr  (acc_addr),
    .acc_wdata (acc_wdata),
    .rd_load   (rd_load),
    .rd_addr   (rd_addr)
  );

  // Stored value with any same-cycle CPU write bytes merged in
  function automatic logic [DATA_W-1:0] fwd_read(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              cpu_we_,
    input logic [ADDR_W-1:0] cpu_addr,
    input logic [NBYTES-1:0] cpu_be,
    input logic [DATA_W-1:0] cpu_data
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if (cpu_we_ == ENABLE_ && cpu_addr == addr) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (cpu_be[b]) v[8*b +: 8] = cpu_data[8*b +: 8];
      end
    end
    if (ZERO_R0 != 0 && addr == '0) v = '0;
    return v;
  endfunction

  // Combinational CPU read ports with write forwarding
  always_comb begin
    ra_data = fwd_read(ra_addr, mem[ra_addr], w_we_, w_addr, w_be, w_data);
    rb_data = fwd_read(rb_addr, mem[rb_addr], w_we_, w_addr, w_be, w_data);
  end

  // Storage update: CPU bytes win over a colliding bus write, bus fills the rest
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      mem <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (!(ZERO_R0 != 0 && i == 0)) begin
          for (int unsigned b = 0; b < NBYTES; b++) begin
            if (w_we_ == ENABLE_ && w_addr == ADDR_W'(i) && w_be[b])
              mem[i][8*b +: 8] <= w_data[8*b +: 8];
            else if (acc_we && acc_addr == ADDR_W'(i))
              mem[i][8*b +: 8] <= acc_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Bus read data, captured on entry to ACK and held otherwise
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      b_rdata <= '0;
    end else if (rd_load) begin
      b_rdata <= fwd_read(rd_addr, mem[rd_addr], w_we_, w_addr, w_be, w_data);
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp against a register-array model.
module tb_regfile_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned WS = 2;
  localparam int unsigned NB = DW/8;
  localparam int unsigned NREG = 2**AW;

  logic          clk = 1'b0;
  logic          reset_;
  logic [AW-1:0] ra_addr, rb_addr, w_addr, b_addr;
  logic [DW-1:0] ra_data, rb_data, w_data, b_wdata, b_rdata;
  logic [NB-1:0] w_be;
  logic          w_we_, b_we_, b_as_, b_cs_, b_rdy_;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .WAIT_ST (WS),
    .ZERO_R0 (1)
  ) dut (
    .clk     (clk),
    .reset_  (reset_),
    .ra_addr (ra_addr),
    .ra_data (ra_data),
    .rb_addr (rb_addr),
    .rb_data (rb_data),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .w_be    (w_be),
    .w_we_   (w_we_),
    .b_addr  (b_addr),
    .b_wdata (b_wdata),
    .b_rdata (b_rdata),
    .b_we_   (b_we_),
    .b_as_   (b_as_),
    .b_cs_   (b_cs_),
    .b_rdy_  (b_rdy_)
  );

  logic [DW-1:0] model [NREG];
  int unsigned   vec_cnt = 0;
  int unsigned   miss_cnt = 0;
  bit            cpu_rand = 1'b0;
  bit            bw_pend = 1'b0;
  logic [AW-1:0] bw_addr;
  logic [DW-1:0] bw_data;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] be_mask(input logic [NB-1:0] be);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < int'(NB); b++)
      if (be[b]) m = m | (DW'(32'hFF) << (8*b));
    return m;
  endfunction

  // Expected combinational read: r0 is zero, pending CPU write bytes show through
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    logic [DW-1:0] m;
    if (a == '0) return '0;
    if (w_we_ == 1'b0 && w_addr == a) begin
      m = be_mask(w_be);
      return (model[a] & ~m) | (w_data & m);
    end
    return model[a];
  endfunction

  task automatic rand_cpu();
    w_we_   = 1'($urandom_range(0, 1));
    w_addr  = AW'($urandom);
    w_be    = NB'($urandom);
    w_data  = $urandom;
    ra_addr = ($urandom_range(0, 2) == 0) ? w_addr : AW'($urandom);
    rb_addr = ($urandom_range(0, 1) == 0) ? w_addr : AW'($urandom);
  endtask

  // One clock: check read ports, then apply this edge's writes to the model
  task automatic cyc();
    logic [DW-1:0] m;
    #2;
    chk("ra_data", ra_data, exp_rd(ra_addr));
    chk("rb_data", rb_data, exp_rd(rb_addr));
    @(posedge clk);
    if (bw_pend && bw_addr != '0) model[bw_addr] = bw_data;
    if (w_we_ == 1'b0 && w_addr != '0) begin
      m = be_mask(w_be);
      model[w_addr] = (model[w_addr] & ~m) | (w_data & m);
    end
    bw_pend = 1'b0;
    #1;
    if (cpu_rand) rand_cpu();
  endtask

  task automatic bus_access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input bit collide, input logic [NB-1:0] cbe,
                            input logic [DW-1:0] cd, input int unsigned hold);
    logic [DW-1:0] last;
    b_cs_ = 1'b0; b_as_ = 1'b0; b_we_ = ~wr; b_addr = a; b_wdata = d;
    cyc();
    b_addr = AW'($urandom); b_wdata = $urandom; b_we_ = 1'($urandom_range(0, 1));
    for (int unsigned k = 0; k < WS; k++) begin
      chk("rdy_wait", DW'(b_rdy_), DW'(1));
      cyc();
    end
    chk("rdy_ack", DW'(b_rdy_), DW'(0));
    if (!wr) chk("b_rdata", b_rdata, model[a]);
    last = b_rdata;
    if (collide) begin
      w_we_ = 1'b0; w_addr = a; w_be = cbe; w_data = cd;
    end
    if (wr) begin
      bw_pend = 1'b1; bw_addr = a; bw_data = d;
    end
    cyc();
    if (collide && !cpu_rand) w_we_ = 1'b1;
    for (int unsigned k = 0; k < hold; k++) begin
      chk("rdy_hold", DW'(b_rdy_), DW'(1));
      chk("rdata_hold", b_rdata, last);
      cyc();
    end
    b_as_ = 1'b1; b_cs_ = 1'b1;
    chk("rdy_release", DW'(b_rdy_), DW'(1));
    cyc();
  endtask

  // Write request withdrawn after 'at' wait cycles: no ready, no write
  task automatic bus_abort(input logic [AW-1:0] a, input logic [DW-1:0] d, input int unsigned at);
    b_cs_ = 1'b0; b_as_ = 1'b0; b_we_ = 1'b0; b_addr = a; b_wdata = d;
    cyc();
    for (int unsigned k = 1; k < at; k++) cyc();
    b_cs_ = 1'b1; b_as_ = 1'b1;
    for (int unsigned k = 0; k < WS + 2; k++) begin
      chk("rdy_abort", DW'(b_rdy_), DW'(1));
      cyc();
    end
  endtask

  // Reset pulsed after 'at' cycles into a read (WS lands in ACK)
  task automatic reset_mid(input int unsigned at);
    cpu_rand = 1'b0; w_we_ = 1'b1;
    b_cs_ = 1'b0; b_as_ = 1'b0; b_we_ = 1'b1; b_addr = AW'(3);
    cyc();
    for (int unsigned k = 0; k < at; k++) cyc();
    if (at == WS) chk("rdy_pre_reset", DW'(b_rdy_), DW'(0));
    else          chk("rdy_pre_reset", DW'(b_rdy_), DW'(1));
    reset_ = 1'b0;
    #1;
    chk("rdy_reset", DW'(b_rdy_), DW'(1));
    chk("rdata_reset", b_rdata, '0);
    for (int i = 0; i < int'(NREG); i++) model[i] = '0;
    b_cs_ = 1'b1; b_as_ = 1'b1;
    @(negedge clk);
    reset_ = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_ = 1'b0;
    ra_addr = '0; rb_addr = '0; w_addr = '0; w_data = '0; w_be = '0; w_we_ = 1'b1;
    b_addr = '0; b_wdata = '0; b_we_ = 1'b1; b_as_ = 1'b1; b_cs_ = 1'b1;
    for (int i = 0; i < int'(NREG); i++) model[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rdy_after_reset", DW'(b_rdy_), DW'(1));
    chk("rdata_after_reset", b_rdata, '0);
    @(negedge clk);
    reset_ = 1'b1;
    @(posedge clk);
    #1;

    // All registers read zero on both ports
    for (int i = 0; i < int'(NREG); i++) begin
      ra_addr = AW'(i); rb_addr = AW'(NREG - 1 - i);
      cyc();
    end

    // Full write, then byte-0 write with forwarding on port B
    w_we_ = 1'b0; w_addr = AW'(3); w_be = 4'b1111; w_data = 32'hDEADBEEF;
    cyc();
    w_be = 4'b0001; w_data = 32'h00000011; ra_addr = AW'(3); rb_addr = AW'(3);
    #1;
    chk("fwd_rb", rb_data, 32'hDEADBE11);
    cyc();
    w_we_ = 1'b1;
    #1;
    chk("ra_reg3", ra_data, 32'hDEADBE11);
    cyc();

    // Register 0 stays zero
    w_we_ = 1'b0; w_addr = '0; w_be = 4'b1111; w_data = 32'hFFFFFFFF; ra_addr = '0;
    #1;
    chk("r0_during", ra_data, '0);
    cyc();
    w_we_ = 1'b1;
    #1;
    chk("r0_after", ra_data, '0);
    cyc();

    // Bus read with held strobe
    bus_access(1'b0, AW'(3), '0, 1'b0, '0, '0, 5);
    chk("bus_rd3", b_rdata, 32'hDEADBE11);

    // Bus write colliding with CPU byte-0 write
    bus_access(1'b1, AW'(5), 32'h12345678, 1'b1, 4'b0001, 32'h000000AA, 0);
    ra_addr = AW'(5);
    #1;
    chk("collide_reg5", ra_data, 32'h123456AA);
    cyc();

    // Aborted writes at first and last wait cycle
    bus_abort(AW'(7), 32'hCAFEF00D, 1);
    bus_abort(AW'(7), 32'hCAFEF00D, WS);
    ra_addr = AW'(7);
    #1;
    chk("abort_reg7", ra_data, '0);
    cyc();

    // Reset during WAIT and during ACK, each followed by a good access
    reset_mid(0);
    ra_addr = AW'(3);
    cyc();
    bus_access(1'b1, AW'(9), 32'hA5A5_5A5A, 1'b0, '0, '0, 1);
    bus_access(1'b0, AW'(9), '0, 1'b0, '0, '0, 0);
    chk("post_reset_rd", b_rdata, 32'hA5A5_5A5A);
    reset_mid(WS);
    bus_access(1'b0, AW'(9), '0, 1'b0, '0, '0, 0);
    chk("post_reset2_rd", b_rdata, '0);

    // Random mixed traffic
    cpu_rand = 1'b1;
    rand_cpu();
    repeat (60) begin
      if ($urandom_range(0, 5) == 0)
        bus_abort(AW'($urandom), $urandom, $urandom_range(1, WS));
      else
        bus_access(1'($urandom_range(0, 1)), AW'($urandom), $urandom,
                   ($urandom_range(0, 2) == 0), NB'($urandom), $urandom,
                   $urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
